// File: rtl/bmu_multicycle_pkg.sv
// bmu_multicycle_pkg: B-extension op codes and shared types for the BMU family
package bmu_multicycle_pkg;
    localparam logic [4:0] OP_CLMUL  = 5'b00001;
    localparam logic [4:0] OP_CLMULH = 5'b00010;
    localparam logic [4:0] OP_CLMULR = 5'b00011;
    localparam logic [4:0] OP_CLZ    = 5'b00100;
    localparam logic [4:0] OP_CPOP   = 5'b00101;
    localparam logic [4:0] OP_CTZ    = 5'b00110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {SEL_CLZ, SEL_CTZ, SEL_CPOP} cnt_sel_t;

    function automatic logic is_clmul(input logic [4:0] op);
        return op == OP_CLMUL || op == OP_CLMULH || op == OP_CLMULR;
    endfunction
endpackage

// File: rtl/bmu_multicycle_bit_counter.sv
// bit_counter: combinational leading-zero, trailing-zero and population count
module bit_counter
    import bmu_multicycle_pkg::*;
(
    input  logic [31:0] x,
    input  cnt_sel_t    sel,
    output logic [5:0]  count
);
    logic [5:0] lz, tz, pop;

    always_comb begin
        lz  = 6'd32;
        tz  = 6'd32;
        pop = '0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) lz = 6'(31 - i);
            if (x[31 - i]) tz = 6'(31 - i);
            pop = pop + 6'(x[i]);
        end
        count = sel == SEL_CLZ ? lz : sel == SEL_CTZ ? tz : pop;
    end
endmodule

// File: rtl/bmu_multicycle.sv
// bmu_multicycle: bit-serial carry-less multiply plus single-step bit counting ops
module bmu_multicycle
    import bmu_multicycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  option,
    input  logic [31:0] in_X,
    input  logic [31:0] in_Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] x_q, x_d, y_q, y_d, result_q, result_d;
    logic [63:0] acc_q, acc_d, partial;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;
    cnt_sel_t    sel;
    logic [5:0]  count;
    logic [31:0] count_res;

    assign sel = option == OP_CLZ ? SEL_CLZ : option == OP_CTZ ? SEL_CTZ : SEL_CPOP;

    bit_counter u_bit_counter (
        .x     (in_X),
        .sel   (sel),
        .count (count)
    );

    // Unrecognised op codes fall through the count path and return X unchanged
    assign count_res = (option == OP_CLZ || option == OP_CTZ || option == OP_CPOP)
                       ? {26'b0, count} : in_X;
    assign partial   = y_q[cnt_q] ? {32'b0, x_q} << cnt_q : 64'b0;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                op_d = option;
                x_d  = in_X;
                y_d  = in_Y;
                if (is_clmul(option)) begin
                    state_d = RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d  = DONE;
                    result_d = count_res;
                end
            end
            RUN: begin
                acc_d = acc_q ^ partial;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = DONE;
                    result_d = op_q == OP_CLMUL  ? acc_d[31:0]
                             : op_q == OP_CLMULH ? acc_d[63:32] : acc_d[62:31];
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_bmu_multicycle.sv
// tb_bmu_multicycle: directed scoreboard bench for bmu_multicycle
module tb_bmu_multicycle;
    import bmu_multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  option = '0;
    logic [31:0] in_X = '0;
    logic [31:0] in_Y = '0;
    logic        busy, done;
    logic [31:0] result;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    bmu_multicycle dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .option (option),
        .in_X   (in_X),
        .in_Y   (in_Y),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r = '0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                if (a[i] && b[j]) r[i + j] = ~r[i + j];
        return r;
    endfunction

    function automatic logic [31:0] clz_ref(input logic [31:0] a);
        int n = 0;
        while (n < 32 && !a[31 - n]) n++;
        return 32'(n);
    endfunction

    function automatic logic [31:0] ctz_ref(input logic [31:0] a);
        int n = 0;
        while (n < 32 && !a[n]) n++;
        return 32'(n);
    endfunction

    function automatic logic [31:0] exp_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p = clmul_ref(a, b);
        case (op)
            OP_CLMUL:  return p[31:0];
            OP_CLMULH: return p[63:32];
            OP_CLMULR: return p[62:31];
            OP_CLZ:    return clz_ref(a);
            OP_CTZ:    return ctz_ref(a);
            OP_CPOP:   return 32'($countones(a));
            default:   return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase in IDLE
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit poke);
        int k;
        bit all_busy;
        logic [31:0] held;
        option = op;
        in_X   = a;
        in_Y   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_of(op, a, b));
        start  = 1'b0;
        option = 5'($urandom);
        in_X   = $urandom;
        in_Y   = $urandom;
        k = 1;
        all_busy = 1'b1;
        while (!done && k < 100) begin
            all_busy &= busy;
            start = poke && k == 5;
            if (start) begin
                option = OP_CLMUL;
                in_X   = 32'h1;
                in_Y   = 32'h1;
            end
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(lat));
        chk({tag, "_busy_run"}, {31'b0, all_busy & busy}, 32'd1);
        chk(tag, result, exp_q.pop_front());
        held  = result;
        start = poke;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_hold"}, result, held);
    endtask

    initial begin
        bit saw_done;
        @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;

        run_op("clmul_3x3", OP_CLMUL, 32'h3, 32'h3, 33, 1'b0);
        chk("clmul_3x3_const", result, 32'h5);
        run_op("clmul_hi_bit", OP_CLMUL, 32'h8000_0000, 32'h2, 33, 1'b0);
        run_op("clmulh_hi_bit", OP_CLMULH, 32'h8000_0000, 32'h2, 33, 1'b0);
        chk("clmulh_hi_bit_const", result, 32'h1);
        run_op("clmulr_hi_bit", OP_CLMULR, 32'h8000_0000, 32'h2, 33, 1'b0);
        chk("clmulr_hi_bit_const", result, 32'h2);
        run_op("clz_bit16", OP_CLZ, 32'h0001_0000, 32'h0, 1, 1'b0);
        chk("clz_bit16_const", result, 32'd15);
        run_op("ctz_zero", OP_CTZ, 32'h0, 32'h0, 1, 1'b0);
        run_op("clz_zero", OP_CLZ, 32'h0, 32'h0, 1, 1'b0);
        run_op("cpop_f0", OP_CPOP, 32'hF0F0_F0F0, 32'h0, 1, 1'b0);
        run_op("cpop_all", OP_CPOP, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);
        run_op("ctz_msb", OP_CTZ, 32'h8000_0000, 32'h0, 1, 1'b0);
        run_op("clmul_ones_poke", OP_CLMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);
        chk("clmul_ones_const", result, 32'h5555_5555);
        run_op("clmulh_ones", OP_CLMULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("clmulr_mix", OP_CLMULR, 32'hDEAD_BEEF, 32'h1357_9BDF, 33, 1'b0);
        run_op("clmul_mix", OP_CLMUL, 32'hA5A5_0F0F, 32'h8421_1248, 33, 1'b0);
        run_op("bad_op", 5'b11111, 32'h1234_5678, 32'h0, 1, 1'b0);

        option = OP_CLMUL;
        in_X   = 32'hFFFF_FFFF;
        in_Y   = 32'hFFFF_FFFF;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        chk("pre_rst_result", result, 32'h1234_5678);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_done", {31'b0, done}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_done |= done;
        end
        chk("rst_no_done", {31'b0, saw_done}, 32'd0);
        chk("rst_idle_busy", {31'b0, busy}, 32'd0);
        run_op("cpop_one", OP_CPOP, 32'h1, 32'h0, 1, 1'b0);
        chk("cpop_one_const", result, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bmu_multicycle.md
BMU_MULTICYCLE -- requirements
Module: bmu_multicycle

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to accept option/operands this cycle.
REQ-005 The block SHALL have port option, input, 5 bits, the B-extension op code shared with the single-cycle BMU: CLMUL=00001, CLMULH=00010, CLMULR=00011, CLZ=00100, CPOP=00101, CTZ=00110.
REQ-006 The block SHALL have ports in_X and in_Y, input, 32 bits each: rs1 and rs2 operands.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in flight.
REQ-008 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, 32 bits, the registered result.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch option, in_X and in_Y at the clock edge.
REQ-012 Accepting a CLMUL, CLMULH or CLMULR op SHALL move the FSM to RUN and clear the 64-bit accumulator and the 5-bit counter.
REQ-013 Accepting any other op SHALL move the FSM directly to DONE.
REQ-014 RUN SHALL process one bit per cycle: if Y[cnt]=1 then acc ^= (zero-extended X << cnt); cnt increments; after cnt=31 is processed the FSM moves to DONE (exactly 32 RUN cycles).
REQ-015 The results SHALL be: CLMUL = acc[31:0], CLMULH = acc[63:32], CLMULR = acc[62:31].
REQ-016 CLZ SHALL return the count of leading zeros of X, giving 32 when X=0.
REQ-017 CTZ SHALL return the count of trailing zeros of X, giving 32 when X=0.
REQ-018 CPOP SHALL return the number of set bits in X, in the range 0..32.
REQ-019 An unrecognised option SHALL take the count path and produce result = X.
REQ-020 Latency SHALL be: for start accepted at edge T, done=1 during the cycle after edge T+1 for count ops and after edge T+33 for clmul ops.
REQ-021 DONE SHALL last exactly one cycle, with done=1 and result updated at DONE entry; the FSM then returns to IDLE.
REQ-022 result SHALL hold its value until the next result update.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-024 start SHALL be ignored while busy=1; operands need be valid only in the accept cycle.
REQ-025 A start arriving in the cycle DONE is active SHALL be ignored; a new op is accepted in the following IDLE cycle at the earliest.

Reset
REQ-026 Asserting rst SHALL force IDLE, busy=0, done=0, result=0, acc=0 and cnt=0 immediately, regardless of clock.
REQ-027 An in-flight operation interrupted by rst SHALL be discarded with no done pulse.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL accept a new op.

Structure
REQ-029 The option encodings SHALL live in a shared package/include used by both BMU and bmu_multicycle, with no local redefinition.
REQ-030 CLZ/CTZ/CPOP SHALL be computed in a combinational sub-module bit_counter (inputs: X and a 2-bit select; output: 6-bit count) that is zero-extended into result.
REQ-031 The carry-less multiply datapath (acc, cnt, shifter) SHALL remain in bmu_multicycle.

Verification
REQ-032 Directed test: CLMUL with X=0x00000003, Y=0x00000003 -> result=0x00000005, with done exactly 33 cycles after accept.
REQ-033 Directed test: X=0x80000000, Y=0x00000002 -> CLMUL=0x00000000, CLMULH=0x00000001, CLMULR=0x00000002.
REQ-034 Directed test: CLZ X=0x00010000 -> 15; CTZ X=0x00000000 -> 32; CPOP X=0xF0F0F0F0 -> 16, each with done one cycle after accept.
REQ-035 Directed test: start CLMUL with X=0xFFFFFFFF, Y=0xFFFFFFFF, then assert start with different operands at cycles 5 and 33 -> both ignored; CLMUL=0x55555555 and CLMULH=0x55555555 from the original operands; busy continuously 1 until IDLE.
REQ-036 Directed test: assert rst at RUN cycle 10 -> busy, done and result go to 0 asynchronously with no done pulse; a subsequent CPOP of 0x00000001 returns 1.
REQ-037 Directed test: option=11111, X=0x12345678 -> done after 1 cycle with result=0x12345678.
